// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates the shared 512x8 big-endian RAM between instruction fetch (IF)
//           and the data path (D) using a MOV/MOC handshake.
// Latency : MOC is high in cycle N+1 after the accepting edge (N = 1/2/4 bytes), or in
//           cycle 1 after accept on an error.
// Backpressure : a requester holds MOV and its operands until its MOC pulse; the port
//                that is not granted waits until the arbiter returns to IDLE.
// Ports:
//   clk, reset             processor clock, synchronous active-high reset
//   if_mov/if_addr         fetch request (always a word read)
//   if_data/if_moc/if_err  fetch result, completion pulse, error flag
//   d_mov/d_rw/d_size/d_addr/d_din   data request (rw 1 = read, size 00/01/10)
//   d_dout/d_moc/d_err     data result (right-aligned), completion pulse, error flag
//   busy                   high whenever the sequencer is not idle
//   ram_addr/ram_rdata/ram_wdata/ram_we   byte-wide RAM port (combinational read)
module mem_port_arbiter #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_mov,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_moc,
  output logic              if_err,
  input  logic              d_mov,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_din,
  output logic [31:0]       d_dout,
  output logic              d_moc,
  output logic              d_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        ram_wdata,
  output logic              ram_we
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t state_q, state_d;

  // Transaction context, captured at the accepting edge.
  logic              gnt_if_q, gnt_if_d;     // 1 = IF owns the current transaction
  logic              last_if_q, last_if_d;   // 1 = most recent grant went to IF
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;             // 1 = read
  logic [2:0]        n_q, n_d;               // bytes in the access: 1, 2 or 4
  logic [2:0]        k_q, k_d;               // current beat
  logic [31:0]       din_q, din_d;
  logic [23:0]       acc_q, acc_d;           // bytes read so far, newest in the low byte
  logic              err_q, err_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       d_dout_q, d_dout_d;

  // ---------------------------------------------------------------------------
  // Request selection and error classification
  // ---------------------------------------------------------------------------
  logic        any_req;
  logic        take_if;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_rw;
  logic [2:0]  req_n;
  logic [32:0] req_last;
  logic        req_err;

  always_comb begin
    any_req  = if_mov | d_mov;
    // On a tie the port that did not win last time is served.
    take_if  = if_mov & (~d_mov | ~last_if_q);
    req_addr = take_if ? if_addr : d_addr;
    req_size = take_if ? 2'b10   : d_size;
    req_rw   = take_if ? 1'b1    : d_rw;
    case (req_size)
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
    // One extra bit so that addresses near 2^32 cannot wrap into range.
    req_last = {1'b0, req_addr} + {30'd0, req_n} - 33'd1;
    req_err  = (req_size == 2'b11)
             | ((req_size == 2'b01) & req_addr[0])
             | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
             | (req_last >= MEM_LIMIT);
  end

  // ---------------------------------------------------------------------------
  // Beat helpers
  // ---------------------------------------------------------------------------
  logic        last_beat;
  logic [31:0] rd_word;
  logic [1:0]  byte_sel;
  logic [7:0]  wr_byte;

  always_comb begin
    last_beat = (k_q == n_q - 3'd1);
    // Shifting each byte in from the right leaves the result big-endian and
    // right-aligned with zero fill, because acc_q starts cleared.
    rd_word   = {acc_q, ram_rdata};
    // Beat k carries the byte at lane N-1-k of the right-aligned write data.
    byte_sel  = 2'(n_q - 3'd1 - k_q);
    wr_byte   = din_q[{byte_sel, 3'b000} +: 8];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = req_err ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Everything is forced low while reset is high so that a reset landing in a
  // write beat suppresses that beat's RAM write on the same edge.
  always_comb begin
    if_moc    = 1'b0;
    if_err    = 1'b0;
    d_moc     = 1'b0;
    d_err     = 1'b0;
    busy      = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    ram_we    = 1'b0;
    if (!reset) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_XFER: begin
          ram_addr = addr_q + ADDR_W'(k_q);
          if (!rw_q) begin
            ram_we    = 1'b1;
            ram_wdata = wr_byte;
          end
        end
        S_DONE: begin
          if_moc = gnt_if_q;
          if_err = gnt_if_q & err_q;
          d_moc  = ~gnt_if_q;
          d_err  = ~gnt_if_q & err_q;
        end
        default: ;
      endcase
    end
  end

  assign if_data = if_data_q;
  assign d_dout  = d_dout_q;

  // ---------------------------------------------------------------------------
  // Datapath: next values
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_if_d  = gnt_if_q;
    last_if_d = last_if_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    n_d       = n_q;
    k_d       = k_q;
    din_d     = din_q;
    acc_d     = acc_q;
    err_d     = err_q;
    if_data_d = if_data_q;
    d_dout_d  = d_dout_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_if_d  = take_if;
          last_if_d = take_if;
          addr_d    = req_addr[ADDR_W-1:0];
          rw_d      = req_rw;
          n_d       = req_n;
          k_d       = 3'd0;
          din_d     = take_if ? 32'd0 : d_din;
          acc_d     = 24'd0;
          err_d     = req_err;
        end
      end
      S_XFER: begin
        k_d = k_q + 3'd1;
        if (rw_q) begin
          acc_d = rd_word[23:0];
          // Publish on the edge that enters DONE; errors never reach here, so
          // a failed access leaves the port's data output untouched.
          if (last_beat) begin
            if (gnt_if_q) begin
              if_data_d = rd_word;
            end else begin
              d_dout_d = rd_word;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_if_q  <= 1'b0;
      last_if_q <= 1'b0;  // last grant = D, so IF wins the first tie
      addr_q    <= '0;
      rw_q      <= 1'b0;
      n_q       <= 3'd0;
      k_q       <= 3'd0;
      din_q     <= 32'd0;
      acc_q     <= 24'd0;
      err_q     <= 1'b0;
      if_data_q <= 32'd0;
      d_dout_q  <= 32'd0;
    end else begin
      gnt_if_q  <= gnt_if_d;
      last_if_q <= last_if_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      n_q       <= n_d;
      k_q       <= k_d;
      din_q     <= din_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      if_data_q <= if_data_d;
      d_dout_q  <= d_dout_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter against a transaction-level model.
// Latency : checks MOC arrival cycle per transaction against size/error rules.
// Backpressure : drives the MOV/MOC handshake, dropping MOV in the IDLE cycle after MOC.
module tb_mem_port_arbiter;

  localparam int MEM = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_mov;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_moc, if_err;
  logic        d_mov, d_rw;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_din, d_dout;
  logic        d_moc, d_err, busy;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_rdata, ram_wdata;
  logic        ram_we;

  mem_port_arbiter #(.MEM_BYTES(MEM), .ADDR_W(9)) dut (
    .clk(clk), .reset(reset),
    .if_mov(if_mov), .if_addr(if_addr), .if_data(if_data), .if_moc(if_moc), .if_err(if_err),
    .d_mov(d_mov), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_din(d_din),
    .d_dout(d_dout), .d_moc(d_moc), .d_err(d_err), .busy(busy),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // RAM array plus a bench-only preload port.
  logic [7:0] mem    [0:MEM-1];
  logic [7:0] shadow [0:MEM-1];
  logic       poke_en;
  logic [8:0] poke_a;
  logic [7:0] poke_d;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (poke_en) mem[poke_a] <= poke_d;
  end

  int n_vec = 0;
  int n_err = 0;
  int d_moc_cnt = 0;
  int moc_both = 0;
  logic [31:0] exp_if_data, exp_d_dout;
  int order[$];

  always @(negedge clk) begin
    if (d_moc) d_moc_cnt++;
    if (if_moc && d_moc) moc_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    poke_a = 9'(a); poke_d = v; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
    shadow[a] = v;
  endtask

  function automatic int size_n(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] s, input logic [31:0] a);
    longint last_byte;
    last_byte = longint'(a) + longint'(size_n(s)) - 1;
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
           (last_byte >= MEM);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] d = 0;
    for (int k = 0; k < n; k++) d = (d << 8) | 32'(shadow[int'(a) + k]);
    return d;
  endfunction

  // One complete transaction on one port, checked against the model.
  task automatic xact(input bit is_if, input bit rw, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] din, input string tag);
    int n, lat, beats, we_beats, bad;
    bit e;
    logic [31:0] got_data, exp_data;
    logic got_err;
    n = size_n(size);
    e = model_err(size, addr);
    lat = 0; beats = 0; we_beats = 0; bad = 0; got_data = 0; got_err = 0;
    @(posedge clk); #1;
    if (is_if) begin
      if_mov = 1'b1; if_addr = addr;
    end else begin
      d_mov = 1'b1; d_rw = rw; d_size = size; d_addr = addr; d_din = din;
    end
    @(posedge clk);  // accepting edge
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(negedge clk);
      if (is_if ? if_moc : d_moc) begin
        lat = c;
        got_data = is_if ? if_data : d_dout;
        got_err = is_if ? if_err : d_err;
      end else if (busy) begin
        if (ram_addr !== 9'(addr + 32'(beats))) bad++;
        if (ram_we) begin
          we_beats++;
          if (ram_wdata !== 8'(din >> (8 * (n - 1 - beats)))) bad++;
        end
        beats++;
      end
    end
    if (lat == 0) chk({tag, "_timeout"}, 1, 0);
    @(posedge clk); #1;
    if (is_if) if_mov = 1'b0; else d_mov = 1'b0;

    chk({tag, "_lat"}, lat, e ? 1 : n + 1);
    chk({tag, "_err"}, {31'd0, got_err}, {31'd0, e});
    chk({tag, "_beats"}, beats, e ? 0 : n);
    chk({tag, "_we_beats"}, we_beats, (!e && !rw) ? n : 0);
    chk({tag, "_beat_bad"}, bad, 0);
    if (is_if) begin
      exp_data = e ? exp_if_data : model_read(addr, n);
      exp_if_data = exp_data;
    end else begin
      exp_data = (e || !rw) ? exp_d_dout : model_read(addr, n);
      exp_d_dout = exp_data;
    end
    chk({tag, "_data"}, got_data, exp_data);
    if (!e && !rw)
      for (int k = 0; k < n; k++) shadow[int'(addr) + k] = 8'(din >> (8 * (n - 1 - k)));
  endtask

  // Requester that re-raises MOV one cycle after dropping it.
  task automatic arb_req(input bit is_if, input int reps);
    bit got;
    for (int r = 0; r < reps; r++) begin
      if (is_if) begin
        if_mov = 1'b1; if_addr = 32'h10;
      end else begin
        d_mov = 1'b1; d_rw = 1'b1; d_size = 2'b00; d_addr = 32'h20;
      end
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (is_if ? if_moc : d_moc) got = 1;
      end
      if (!got) chk(is_if ? "arb_if_timeout" : "arb_d_timeout", 1, 0);
      else order.push_back(is_if ? 0 : 1);
      @(posedge clk); #1;
      if (is_if) if_mov = 1'b0; else d_mov = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] old42, old43;
    int mc0, mism;
    logic [1:0] sz;
    logic [31:0] a;
    bit port_if, rw;
    reset = 1'b1; poke_en = 1'b0; poke_a = 0; poke_d = 0;
    if_mov = 0; if_addr = 0; d_mov = 0; d_rw = 0; d_size = 0; d_addr = 0; d_din = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {26'd0, if_moc, d_moc, if_err, d_err, ram_we, busy}, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_dout", d_dout, 0);
    chk("rst_ram_addr", {23'd0, ram_addr}, 0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 0);

    for (int i = 0; i < MEM; i++) poke(i, 8'($urandom));
    poke(16'h10, 8'h8C); poke(16'h11, 8'h22); poke(16'h12, 8'h00); poke(16'h13, 8'h04);
    reset = 1'b0;
    exp_if_data = 0; exp_d_dout = 0;

    // Word fetch.
    xact(1, 1, 2'b10, 32'h10, 0, "fetch");
    chk("fetch_word", if_data, 32'h8C220004);

    // Byte write then halfword read.
    xact(0, 0, 2'b00, 32'h21, 32'h000000AB, "wr_byte");
    poke(16'h20, 8'h12);
    xact(0, 1, 2'b01, 32'h20, 0, "rd_half");
    chk("rd_half_word", d_dout, 32'h000012AB);

    // Errors leave d_dout alone.
    xact(0, 1, 2'b10, 32'h22, 0, "err_misalign");
    xact(0, 1, 2'b10, 32'h1FE, 0, "err_range");
    xact(0, 1, 2'b11, 32'h0, 0, "err_size");
    chk("err_dout_kept", d_dout, 32'h000012AB);

    // Arbitration with both requesters continuously busy.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_if_data = 0; exp_d_dout = 0;
    order.delete();
    fork
      arb_req(1, 2);
      arb_req(0, 2);
    join
    chk("arb_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk($sformatf("arb_grant%0d", k), order[k], k % 2);
    exp_if_data = model_read(32'h10, 4);
    exp_d_dout = model_read(32'h20, 1);

    // Reset in the middle of a word write, during beat 2.
    old42 = shadow[16'h42]; old43 = shadow[16'h43];
    mc0 = d_moc_cnt;
    @(posedge clk); #1;
    d_mov = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 32'h40; d_din = 32'hDEADBEEF;
    @(posedge clk);                   // accept
    @(posedge clk); @(posedge clk);   // end of beats 0 and 1
    #1 reset = 1'b1; d_mov = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", {31'd0, ram_we}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_moc", d_moc_cnt, mc0);
    chk("rst_mid_b0", {24'd0, mem[16'h40]}, 32'hDE);
    chk("rst_mid_b1", {24'd0, mem[16'h41]}, 32'hAD);
    chk("rst_mid_b2", {24'd0, mem[16'h42]}, {24'd0, old42});
    chk("rst_mid_b3", {24'd0, mem[16'h43]}, {24'd0, old43});
    shadow[16'h40] = 8'hDE; shadow[16'h41] = 8'hAD;
    exp_if_data = 0; exp_d_dout = 0;
    xact(1, 1, 2'b10, 32'h40, 0, "fetch_after_rst");

    // Randomized single-port traffic.
    for (int t = 0; t < 120; t++) begin
      port_if = ($urandom_range(0, 2) == 0);
      sz = port_if ? 2'b10 : (($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2)));
      rw = port_if ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: a = $urandom;
        1: a = 32'h1F8 + 32'($urandom_range(0, 7));
        default: a = 32'($urandom_range(0, MEM - 1));
      endcase
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_n(sz)) - 1);
      xact(port_if, rw, sz, a, $urandom, $sformatf("rnd%0d", t));
    end

    mism = 0;
    for (int i = 0; i < MEM; i++) if (mem[i] !== shadow[i]) mism++;
    chk("ram_image", mism, 0);
    chk("moc_overlap", moc_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the shared byte-wide program/data RAM (512 x 8, big-endian) between two requesters: instruction fetch (IF) and the data path (D).
- Uses a MOV/MOC handshake: requester asserts MOV, and the controller pulses MOC when the access is complete.
- Converts byte, halfword and word requests into serial byte beats. Runs entirely on the processor clock.
- Sits between the CPU control unit and the RAM array. Replaces ad-hoc direct RAM drive by the datapath.

Parameters:
- MEM_BYTES, 512, number of addressable bytes; any address >= MEM_BYTES is an error.
- ADDR_W, 9, width of the RAM-side byte address.

Ports:
- clk  input  1  processor clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- if_mov  input  1  fetch request; held with if_addr until if_moc.
- if_addr  input  32  fetch byte address (word access).
- if_data  output  32  fetched instruction; valid from if_moc, held until next IF completion.
- if_moc  output  1  one-cycle fetch-complete pulse.
- if_err  output  1  valid with if_moc; misaligned or out-of-range fetch.
- d_mov  input  1  data request; held with other d_* inputs until d_moc.
- d_rw  input  1  1 = read, 0 = write.
- d_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- d_addr  input  32  data byte address.
- d_din  input  32  write data, right-aligned.
- d_dout  output  32  read data, right-aligned, zero-extended.
- d_moc  output  1  one-cycle data-complete pulse.
- d_err  output  1  valid with d_moc.
- busy  output  1  high in any state except IDLE.
- ram_addr  output  ADDR_W  RAM byte address.
- ram_rdata  input  8  RAM read byte; combinational from ram_addr.
- ram_wdata  output  8  RAM write byte.
- ram_we  output  1  RAM write enable; RAM writes on the rising clk edge.

Behaviour:
- States: IDLE, XFER, DONE.
- Reset, whenever asserted:
  - state = IDLE.
  - if_data, d_dout, ram_addr, ram_wdata = 0.
  - if_moc, d_moc, if_err, d_err, ram_we, busy = 0.
  - last_grant = D.
  - Reset mid-transfer aborts immediately: no MOC is issued, and bytes already written stay written.
- IDLE:
  - At a rising edge, if exactly one MOV is high, accept that request.
  - If both MOVs are high, grant the port not equal to last_grant, then set last_grant to the granted port. After reset, IF therefore wins first.
  - On accept, latch addr, rw, size and din. Set N = 1/2/4 bytes (IF is always 4). Set beat k = 0.
- Error check at accept: the access is an error if any of the following holds:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr + N - 1 >= MEM_BYTES.
  - On error, go directly to DONE with err = 1. No RAM access; the port's data output is unchanged.
- XFER, one byte per cycle, k = 0..N-1:
  - ram_addr = addr + k.
  - Read beat:
    - ram_we = 0.
    - At the edge ending the beat, shift ram_rdata into the accumulator. Byte k lands at bits [8(N-1-k)+7 : 8(N-1-k)], i.e. big-endian.
  - Write beat:
    - ram_we = 1.
    - ram_wdata = d_din[8(N-1-k)+7 : 8(N-1-k)].
  - After beat N-1, go to DONE.
- DONE (one cycle):
  - The granted port's MOC = 1, and its err is valid.
  - For a successful read, the data output is updated at the edge entering DONE.
  - Next state is IDLE.
- Latency: MOC is high during the (N+1)th cycle after the accepting edge. Error MOC is high in the first cycle after accept.
- Back-to-back requests:
  - A requester must drop MOV in the IDLE cycle following MOC. If MOV is still high there, it is accepted as a new request.
  - There is a minimum of one IDLE cycle between transactions.
- Invariants:
  - ram_we is 0 outside write XFER beats.
  - The non-granted MOV is ignored until IDLE.
  - MOC is never asserted for both ports in the same cycle.

Test Plan:
- Word fetch:
  - Stimulus: preload RAM[0x10..0x13] = 8C,22,00,04; pulse reset; assert if_mov with if_addr = 0x10.
  - Required: if_moc high exactly in cycle 5 after accept; if_data = 0x8C220004; if_err = 0; ram_we never 1.
- Byte write then halfword read:
  - Stimulus: d write, size 00, addr 0x21, din 0x000000AB; then read, size 01, addr 0x20, with RAM[0x20] = 0x12.
  - Required for the write: one beat with ram_addr = 0x21, ram_wdata = 0xAB, ram_we = 1; d_moc in cycle 2 after accept.
  - Required for the read: d_dout = 0x000012AB.
- Arbitration:
  - Stimulus: both MOVs high continuously after reset, each requester re-raising MOV one cycle after its MOC.
  - Required: grant order IF, D, IF, D; MOCs never coincide.
- Errors:
  - Stimulus: d word read at 0x22; word read at 0x1FE; size 11.
  - Required: each gives d_moc with d_err = 1 in cycle 1 after accept; no ram_addr beats; d_dout unchanged from its prior value.
- Reset mid-write:
  - Stimulus: word write 0xDEADBEEF at 0x40; assert reset during beat k = 2.
  - Required: RAM[0x40] = DE and RAM[0x41] = AD; RAM[0x42..0x43] untouched; no d_moc; busy = 0 next cycle.
  - Follow-up: a subsequent fetch completes normally.
